// File: rtl/reg_writeback.sv
// reg_writeback: two-source writeback arbiter for a register file.
// Each source (ALU, LSU) owns a one-entry holding slot. A round-robin
// pointer decides which full slot reaches the registered write port when
// both are full. Pending writes in the slots and in the output stage can
// be forwarded combinationally to two read-query ports.
module reg_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              lsu_valid,
    input  logic [REG_W-1:0]  lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,

    output logic              wena,
    output logic [REG_W-1:0]  waddr,
    output logic [DATA_W-1:0] wdata,

    input  logic [REG_W-1:0]  qaddr1,
    input  logic [REG_W-1:0]  qaddr2,
    output logic              qhit1,
    output logic              qhit2,
    output logic [DATA_W-1:0] qdata1,
    output logic [DATA_W-1:0] qdata2,

    output logic              idle
);

    // Holding slots, one per source.
    logic              alu_full;
    logic [REG_W-1:0]  alu_slot_rd;
    logic [DATA_W-1:0] alu_slot_data;
    logic              lsu_full;
    logic [REG_W-1:0]  lsu_slot_rd;
    logic [DATA_W-1:0] lsu_slot_data;

    // Tie-break pointer: 0 favours the ALU, 1 favours the LSU.
    logic              rr_ptr;

    logic              alu_grant;
    logic              lsu_grant;
    logic              conflict;
    logic              alu_xfer;
    logic              lsu_xfer;

    // Grant and ready decisions from current slot state only (never from valid).
    always_comb begin
        conflict  = alu_full && lsu_full;
        alu_grant = alu_full && (!lsu_full || !rr_ptr);
        lsu_grant = lsu_full && (!alu_full ||  rr_ptr);
        alu_ready = !alu_full || alu_grant;
        lsu_ready = !lsu_full || lsu_grant;
        alu_xfer  = alu_valid && alu_ready;
        lsu_xfer  = lsu_valid && lsu_ready;
    end

    // ALU slot: fill on a transfer to a nonzero rd, drain when granted.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; a blocking = here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_full      <= 1'b0;
            alu_slot_rd   <= '0;
            alu_slot_data <= '0;
        end else if (alu_xfer && alu_rd != '0) begin
            alu_full      <= 1'b1;
            alu_slot_rd   <= alu_rd;
            alu_slot_data <= alu_data;
        end else if (alu_grant) begin
            alu_full      <= 1'b0;
        end
    end

    // LSU slot: same behaviour as the ALU slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_full      <= 1'b0;
            lsu_slot_rd   <= '0;
            lsu_slot_data <= '0;
        end else if (lsu_xfer && lsu_rd != '0) begin
            lsu_full      <= 1'b1;
            lsu_slot_rd   <= lsu_rd;
            lsu_slot_data <= lsu_data;
        end else if (lsu_grant) begin
            lsu_full      <= 1'b0;
        end
    end

    // Round-robin pointer: on a conflict, hand priority to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (conflict) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Output stage: register the granted slot; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wena  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wena <= alu_grant || lsu_grant;
            if (alu_grant) begin
                waddr <= alu_slot_rd;
                wdata <= alu_slot_data;
            end else if (lsu_grant) begin
                waddr <= lsu_slot_rd;
                wdata <= lsu_slot_data;
            end
        end
    end

    // Forwarding lookup: LSU slot, then ALU slot, then the output stage.
    // x0 never hits, so its result is always {0, 0}.
    function automatic logic [DATA_W:0] lookup(input logic [REG_W-1:0] q);
        logic [DATA_W:0] r;
        r = '0;
        if (q != '0) begin
            if (lsu_full && lsu_slot_rd == q) begin
                r = {1'b1, lsu_slot_data};
            end else if (alu_full && alu_slot_rd == q) begin
                r = {1'b1, alu_slot_data};
            end else if (wena && waddr == q) begin
                r = {1'b1, wdata};
            end
        end
        return r;
    endfunction

    // Combinational forwarding for both query ports.
    // NOTE: every output of an always_comb must be written on every path;
    // lookup() starts from a zero default so no latch can be inferred.
    always_comb begin
        {qhit1, qdata1} = lookup(qaddr1);
        {qhit2, qdata2} = lookup(qaddr2);
    end

    // Idle when nothing is held anywhere in the pipeline.
    always_comb begin
        idle = !alu_full && !lsu_full && !wena;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed table, reset and
// back-pressure sequences, and randomized traffic against a queue model.
module tb_reg_writeback;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, lsu_valid;
    logic [RW-1:0] alu_rd, lsu_rd;
    logic [DW-1:0] alu_data, lsu_data;
    logic          alu_ready, lsu_ready;
    logic          wena;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [RW-1:0] qaddr1, qaddr2;
    logic          qhit1, qhit2;
    logic [DW-1:0] qdata1, qdata2;
    logic          idle;

    reg_writeback #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wena(wena), .waddr(waddr), .wdata(wdata),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .qhit1(qhit1), .qhit2(qhit2),
        .qdata1(qdata1), .qdata2(qdata2), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed { logic [RW-1:0] rd; logic [DW-1:0] data; } ent_t;
    typedef struct packed { logic valid; logic [RW-1:0] rd; logic [DW-1:0] data; } out_t;
    typedef enum { W_NONE, W_ALU, W_LSU } win_t;

    ent_t m_alu[$];        // pending ALU write (0 or 1 entries)
    ent_t m_lsu[$];        // pending LSU write (0 or 1 entries)
    bit   m_lsu_turn;      // who wins the next tie
    out_t m_out;           // write port as seen after the last edge
    ent_t wlog[$];         // writes actually observed on the port

    function automatic win_t m_winner();
        if (m_alu.size() != 0 && m_lsu.size() != 0) return m_lsu_turn ? W_LSU : W_ALU;
        if (m_alu.size() != 0) return W_ALU;
        if (m_lsu.size() != 0) return W_LSU;
        return W_NONE;
    endfunction

    function automatic logic [DW:0] m_fwd(input logic [RW-1:0] q);
        if (q == 0) return '0;
        if (m_lsu.size() != 0 && m_lsu[0].rd == q) return {1'b1, m_lsu[0].data};
        if (m_alu.size() != 0 && m_alu[0].rd == q) return {1'b1, m_alu[0].data};
        if (m_out.valid && m_out.rd == q) return {1'b1, m_out.data};
        return '0;
    endfunction

    function automatic void m_reset();
        m_alu.delete();
        m_lsu.delete();
        m_lsu_turn = 1'b0;
        m_out = '0;
    endfunction

    // One clock cycle driven and checked against the model. Entered and left at posedge+1.
    task automatic do_cycle(input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] ad,
                            input logic lv, input logic [RW-1:0] lrd, input logic [DW-1:0] ld,
                            input logic [RW-1:0] q1, input logic [RW-1:0] q2,
                            output bit a_acc, output bit l_acc);
        win_t          win;
        bit            e_ardy, e_lrdy, tie;
        logic [DW:0]   f1, f2;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        qaddr1 = q1; qaddr2 = q2;
        @(negedge clk);
        win    = m_winner();
        e_ardy = (m_alu.size() == 0) || (win == W_ALU);
        e_lrdy = (m_lsu.size() == 0) || (win == W_LSU);
        f1 = m_fwd(q1);
        f2 = m_fwd(q2);
        check("alu_ready", alu_ready, e_ardy);
        check("lsu_ready", lsu_ready, e_lrdy);
        check("qhit1", qhit1, f1[DW]);
        check("qdata1", qdata1, f1[DW-1:0]);
        check("qhit2", qhit2, f2[DW]);
        check("qdata2", qdata2, f2[DW-1:0]);
        check("idle", idle, m_alu.size() == 0 && m_lsu.size() == 0 && !m_out.valid);
        // Advance the model across the edge.
        tie = (m_alu.size() != 0) && (m_lsu.size() != 0);
        if (win == W_ALU) begin
            m_out = {1'b1, m_alu[0].rd, m_alu[0].data};
            void'(m_alu.pop_front());
        end else if (win == W_LSU) begin
            m_out = {1'b1, m_lsu[0].rd, m_lsu[0].data};
            void'(m_lsu.pop_front());
        end else begin
            m_out.valid = 1'b0;
        end
        if (tie) m_lsu_turn = (win == W_ALU);
        a_acc = av && e_ardy;
        l_acc = lv && e_lrdy;
        if (a_acc && ard != 0) m_alu.push_back({ard, ad});
        if (l_acc && lrd != 0) m_lsu.push_back({lrd, ld});
        @(posedge clk);
        #1;
        check("wena", wena, m_out.valid);
        check("waddr", waddr, m_out.rd);
        check("wdata", wdata, m_out.data);
        if (wena) wlog.push_back({waddr, wdata});
    endtask

    task automatic idle_cycle(input logic [RW-1:0] q1, input logic [RW-1:0] q2);
        bit a, l;
        do_cycle(1'b0, '0, '0, 1'b0, '0, '0, q1, q2, a, l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        wlog.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          av;  logic [RW-1:0] ard; logic [DW-1:0] ad;
        logic          lv;  logic [RW-1:0] lrd; logic [DW-1:0] ld;
        logic [RW-1:0] q1;
        logic          e_ardy, e_lrdy, e_qh;  logic [DW-1:0] e_qd;   // before the edge
        logic          e_wena; logic [RW-1:0] e_waddr; logic [DW-1:0] e_wdata; logic e_idle; // after
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [RW-1:0] ard, input logic [DW-1:0] ad,
                                input logic lv, input logic [RW-1:0] lrd, input logic [DW-1:0] ld,
                                input logic [RW-1:0] q1,
                                input logic ea, input logic el, input logic eh, input logic [DW-1:0] ed,
                                input logic ew, input logic [RW-1:0] ewa, input logic [DW-1:0] ewd,
                                input logic ei);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld; v.q1 = q1;
        v.e_ardy = ea; v.e_lrdy = el; v.e_qh = eh; v.e_qd = ed;
        v.e_wena = ew; v.e_waddr = ewa; v.e_wdata = ewd; v.e_idle = ei;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a_acc, l_acc;
        int ak, lk;

        //           av ard  ad       lv lrd ld     q1   ardy lrdy qh qd       wena waddr wdata    idle
        tbl[0]  = mk(1, 3,  'h1234,  0, 0,  0,     3,   1, 1, 0, 0,          0, 0,  0,       0); // ALU alone
        tbl[1]  = mk(0, 0,  0,       0, 0,  0,     3,   1, 1, 1, 'h1234,     1, 3,  'h1234,  0);
        tbl[2]  = mk(0, 0,  0,       0, 0,  0,     3,   1, 1, 1, 'h1234,     0, 3,  'h1234,  1);
        tbl[3]  = mk(1, 5,  'hA,     1, 6,  'hB,   0,   1, 1, 0, 0,          0, 3,  'h1234,  0); // conflict
        tbl[4]  = mk(0, 0,  0,       0, 0,  0,     6,   1, 0, 1, 'hB,        1, 5,  'hA,     0);
        tbl[5]  = mk(0, 0,  0,       0, 0,  0,     5,   1, 1, 1, 'hA,        1, 6,  'hB,     0);
        tbl[6]  = mk(1, 7,  'h11,    1, 8,  'h22,  6,   1, 1, 1, 'hB,        0, 6,  'hB,     0); // LSU's turn
        tbl[7]  = mk(0, 0,  0,       0, 0,  0,     7,   0, 1, 1, 'h11,       1, 8,  'h22,    0);
        tbl[8]  = mk(0, 0,  0,       0, 0,  0,     0,   1, 1, 0, 0,          1, 7,  'h11,    0);
        tbl[9]  = mk(0, 0,  0,       1, 0,  'hFF,  0,   1, 1, 0, 0,          0, 7,  'h11,    1); // x0
        tbl[10] = mk(0, 0,  0,       1, 0,  'hFF,  0,   1, 1, 0, 0,          0, 7,  'h11,    1);
        tbl[11] = mk(1, 9,  'hDEAD,  1, 0,  'hFF,  0,   1, 1, 0, 0,          0, 7,  'h11,    0);
        tbl[12] = mk(0, 0,  0,       0, 0,  0,     9,   1, 1, 1, 'hDEAD,     1, 9,  'hDEAD,  0);
        tbl[13] = mk(1, 10, 'h100,   1, 11, 'h200, 9,   1, 1, 1, 'hDEAD,     0, 9,  'hDEAD,  0); // pointer back at ALU
        tbl[14] = mk(0, 0,  0,       0, 0,  0,     11,  1, 0, 1, 'h200,      1, 10, 'h100,   0);
        tbl[15] = mk(0, 0,  0,       0, 0,  0,     10,  1, 1, 1, 'h100,      1, 11, 'h200,   0);
        tbl[16] = mk(0, 0,  0,       0, 0,  0,     11,  1, 1, 1, 'h200,      0, 11, 'h200,   1);

        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        qaddr1 = 0; qaddr2 = 0;
        do_reset();

        // Reset state.
        check("rst wena", wena, 1'b0);
        check("rst waddr", waddr, '0);
        check("rst wdata", wdata, '0);
        check("rst alu_ready", alu_ready, 1'b1);
        check("rst lsu_ready", lsu_ready, 1'b1);
        check("rst idle", idle, 1'b1);

        // Directed vectors; query port 2 mirrors port 1.
        for (int i = 0; i < 17; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            qaddr1 = tbl[i].q1; qaddr2 = tbl[i].q1;
            @(negedge clk);
            check($sformatf("t%0d alu_ready", i), alu_ready, tbl[i].e_ardy);
            check($sformatf("t%0d lsu_ready", i), lsu_ready, tbl[i].e_lrdy);
            check($sformatf("t%0d qhit1", i), qhit1, tbl[i].e_qh);
            check($sformatf("t%0d qdata1", i), qdata1, tbl[i].e_qd);
            check($sformatf("t%0d qhit2", i), qhit2, tbl[i].e_qh);
            check($sformatf("t%0d qdata2", i), qdata2, tbl[i].e_qd);
            @(posedge clk); #1;
            check($sformatf("t%0d wena", i), wena, tbl[i].e_wena);
            check($sformatf("t%0d waddr", i), waddr, tbl[i].e_waddr);
            check($sformatf("t%0d wdata", i), wdata, tbl[i].e_wdata);
            check($sformatf("t%0d idle", i), idle, tbl[i].e_idle);
        end

        // Asynchronous reset with both slots full and a write on the port.
        do_reset();
        do_cycle(1, 3, 'h33, 1, 12, 'h44, 0, 0, a_acc, l_acc);
        do_cycle(1, 4, 'h55, 1, 13, 'h66, 3, 12, a_acc, l_acc);
        check("pre-rst wena", wena, 1'b1);
        alu_valid = 0; lsu_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("async wena", wena, 1'b0);
        check("async waddr", waddr, '0);
        check("async wdata", wdata, '0);
        check("async alu_ready", alu_ready, 1'b1);
        check("async lsu_ready", lsu_ready, 1'b1);
        check("async idle", idle, 1'b1);
        #2 rst = 1'b0;
        m_reset();
        wlog.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) idle_cycle(4, 12);
        check("post-rst writes", wlog.size(), 0);

        // Back-pressure: both sources valid for 8 cycles, pointer starts at ALU.
        do_reset();
        ak = 0; lk = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(1, RW'(1 + ak), DW'(32'hA000 + ak), 1, RW'(16 + lk), DW'(32'hB000 + lk),
                     RW'(1 + ak), RW'(16 + lk), a_acc, l_acc);
            if (a_acc) ak++;
            if (l_acc) lk++;
        end
        for (int i = 0; i < 4; i++) idle_cycle(0, 0);
        check("bp write count", wlog.size(), 9);
        for (int i = 0; i < 9 && i < wlog.size(); i++) begin
            if (i % 2 == 0)
                check($sformatf("bp write %0d", i), wlog[i], {RW'(1 + i / 2), DW'(32'hA000 + i / 2)});
            else
                check($sformatf("bp write %0d", i), wlog[i], {RW'(16 + i / 2), DW'(32'hB000 + i / 2)});
        end

        // Randomized traffic; the two sources use disjoint nonzero rd ranges.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic          av, lv;
            logic [RW-1:0] ard, lrd;
            av  = ($urandom_range(0, 99) < 70);
            lv  = ($urandom_range(0, 99) < 60);
            ard = RW'($urandom_range(0, 7));
            lrd = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(8, 15));
            do_cycle(av, ard, DW'($urandom), lv, lrd, DW'($urandom),
                     RW'($urandom_range(0, 15)), RW'($urandom_range(0, 15)), a_acc, l_acc);
        end
        for (int i = 0; i < 4; i++) idle_cycle(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, the register data width (equal to DATA_BUS).
REQ-002 The block SHALL take parameter REG_W, default 5, the register index width (equal to REG_BUS).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_rd  input  REG_W  ALU destination register.
REQ-007 alu_data  input  DATA_W  ALU result.
REQ-008 alu_ready  output  1  ALU offer accepted this cycle when alu_valid is also high.
REQ-009 lsu_valid, lsu_rd, lsu_data, lsu_ready SHALL have the same widths and meanings as the ALU source, for load results.
REQ-010 wena  output  1  registered write enable to the register file.
REQ-011 waddr  output  REG_W  registered write index.
REQ-012 wdata  output  DATA_W  registered write data.
REQ-013 qaddr1, qaddr2  input  REG_W  forwarding query indices.
REQ-014 qhit1, qhit2  output  1  query matches a pending write.
REQ-015 qdata1, qdata2  output  DATA_W  forwarded data, 0 when no hit.
REQ-016 idle  output  1  both slots and the output stage are empty.

Function
REQ-017 Each source SHALL own one holding slot (full flag, rd, data).
REQ-018 A transfer SHALL occur on a posedge where valid and ready are both high.
REQ-019 ready SHALL be high when the slot is empty or the slot is granted this cycle; ready SHALL NOT depend combinationally on valid.
REQ-020 A transfer with rd == 0 SHALL be consumed without filling the slot and SHALL never produce a write.
REQ-021 Grant: one full slot gets the grant; if both are full, the slot named by a 1-bit round-robin pointer wins (0 = ALU, 1 = LSU).
REQ-022 After a conflict grant, the pointer SHALL toggle to the loser; grants without conflict SHALL leave it unchanged.
REQ-023 At each posedge with a grant, the granted slot's rd and data SHALL load into waddr/wdata and wena SHALL be set to 1; the slot SHALL empty, or refill if its source transfers in the same cycle.
REQ-024 With no grant, wena SHALL be 0 on the next cycle; waddr and wdata SHALL hold their values.
REQ-025 Latency: a transfer at edge N with an empty, uncontended slot SHALL give wena = 1 after edge N+1.
REQ-026 Sustained throughput SHALL be one write per cycle in total; a single source alone SHALL achieve one transfer per cycle.
REQ-027 Forwarding search order SHALL be: LSU slot, then ALU slot, then output stage (wena = 1); the first match supplies qdata.
REQ-028 A query with qaddr == 0 SHALL return qhit = 0 and qdata = 0.
REQ-029 Forwarding SHALL be combinational from current state and qaddr.
REQ-030 Two in-flight writes to the same nonzero rd from different sources are excluded by issue logic; the result is then unspecified but SHALL NOT corrupt other state.
REQ-031 idle SHALL equal !alu_full && !lsu_full && !wena.

Reset
REQ-032 rst high SHALL immediately clear both slots, set the pointer to 0, and drive wena, waddr and wdata to 0; alu_ready and lsu_ready then read 1.
REQ-033 Reset mid-operation SHALL discard all pending writes; no write SHALL appear after rst deasserts unless a new transfer occurs.

Verification
REQ-034 ALU alone: rd = 3, data = 0x1234 at edge 0 -> wena = 1, waddr = 3, wdata = 0x1234 after edge 1; qaddr1 = 3 gives qhit1 = 1 and qdata1 = 0x1234 during cycles 0-1.
REQ-035 Conflict: both sources transfer at edge 0 (ALU rd = 5, data = 0xA; LSU rd = 6, data = 0xB), pointer = 0 -> edge 1 writes x5, edge 2 writes x6; pointer = 0 again after the next conflict.
REQ-036 Back-pressure: ALU and LSU valid every cycle for 8 cycles -> writes alternate between sources, with no lost or duplicated data; the loser's ready is low while its slot is held.
REQ-037 x0: LSU rd = 0, data = 0xFF -> lsu_ready = 1, no wena pulse, qhit = 0 for qaddr = 0, idle stays 1.
REQ-038 Async reset: assert rst between edges with both slots full -> outputs go to 0 before the next edge; no writes occur after release.
